cond_exec_unit: RTL and testbench
=================================

// Module: cond_exec_unit
// PURPOSE
//  Parametrised conditional-execution unit for the CPU execute stage. It generalises the
//  2-bit jump-condition unit to the full 4-bit NZCV condition set.
//  - Holds NUM_BANKS banked NZCV flag registers.
//  - Predicates every instruction, not only jumps.
//  - Drives a multi-cycle pipeline flush after a taken jump, squashing younger instructions.
// PARAMETERS
//  NUM_BANKS     2  number of independent NZCV flag contexts (>=1)
//  FLUSH_CYCLES  2  cycles flush stays high after a taken jump (0 = no flush/squash)
//  BANK_W        $clog2(NUM_BANKS) (min 1)  width of bank_sel; derived, do not override
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous reset, active-high
//  en          in   1       instruction valid in this cycle
//  cond        in   4       condition code of the instruction
//  is_jmp      in   1       instruction is a jump (wpci)
//  flag_we     in   1       instruction writes flags
//  alu_nzcv    in   4       {N,Z,C,V} produced by the ALU for this instruction
//  bank_sel    in   BANK_W  flag bank used for evaluation, write and flags_o
//  exec_ok     out  1       registered: previous-cycle instruction executes (commit write-back)
//  jmp_taken   out  1       registered: previous-cycle jump taken (load PC)
//  flush       out  1       registered: squash window active
//  flags_o     out  4       combinational read of bank[bank_sel], {N,Z,C,V}
// BEHAVIOUR
//  Reset (rst=1 at an edge)
//   - All banks <= 4'b0000.
//   - exec_ok, jmp_taken, flush <= 0; flush counter <= 0.
//   - rst has priority over every other input, including mid-flush.
//  Condition decode, evaluated on the current bank[bank_sel] (pre-write value):
//   0000 EQ Z        0001 NE !Z        0010 CS C          0011 CC !C
//   0100 MI N        0101 PL !N        0110 VS V          0111 VC !V
//   1000 HI C&!Z     1001 LS !C|Z      1010 GE N==V       1011 LT N!=V
//   1100 GT !Z&(N==V)                  1101 LE Z|(N!=V)
//   1110 AL 1        1111 NV 0
//  squash = (flush counter != 0). live = en & !squash. pass = live & cond_true.
//  Latency: inputs sampled at edge t; outputs valid for exactly one cycle after edge t.
//   - exec_ok   <= pass.
//   - jmp_taken <= pass & is_jmp.
//  Flag write: if pass & flag_we, bank[bank_sel] <= alu_nzcv at edge t.
//   - Other banks are untouched.
//   - A failed or squashed instruction never writes flags.
//   - Same-instruction flag write and jump: the condition uses the old flags, then the
//     flags update and the jump is taken.
//  Back-to-back: the instruction at t+1 sees the flags written at t (no forwarding needed).
//  Flush counter (width fits FLUSH_CYCLES):
//   - When pass & is_jmp & FLUSH_CYCLES>0: counter <= FLUSH_CYCLES;
//     otherwise it decrements to 0 and saturates there.
//   - flush = registered (counter != 0), i.e. high on cycles t+1 .. t+FLUSH_CYCLES.
//   - Instructions presented while flush=1 are squashed: exec_ok=0, jmp_taken=0,
//     no flag write, no counter reload.
//  en=0: no state change except the counter decrement; exec_ok=jmp_taken=0 next cycle.
//  bank_sel >= NUM_BANKS (non-power-of-2 case):
//   - treated as bank 0 for both read and write;
//   - flags_o likewise shows bank 0.
// TESTING
//  1 rst=1 one edge with en=1 cond=AL is_jmp=1
//      -> exec_ok=0, jmp_taken=0, flush=0, flags_o=0000 after the edge.
//  2 bank0 flags Z=1; en, cond=0000, is_jmp=1 -> next cycle jmp_taken=1, exec_ok=1;
//      with FLUSH_CYCLES=2, flush=1 for exactly 2 cycles.
//  3 flags N=1 V=0 Z=0, cond=1100 GT, is_jmp -> jmp_taken=0, exec_ok=0, flush stays 0;
//      cond=1011 LT -> jmp_taken=1.
//  4 Back-to-back:
//      - instr A: cond=AL, flag_we=1, alu_nzcv=0100;
//      - next cycle instr B: cond=NE, is_jmp -> B jmp_taken=0; flags_o=0100.
//  5 Cycle after a taken jump: en, cond=AL, flag_we=1, alu_nzcv=1111, is_jmp
//      -> exec_ok=0, jmp_taken=0, flags unchanged, flush not extended.
//  6 Bank isolation (bank1 write, bank0 read) and NV (cond=1111 never executes);
//      rst asserted mid-flush -> flush=0 next cycle.

Source files
------------

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: conditional-execution unit for the execute stage.
// It holds NUM_BANKS banked NZCV flag registers and evaluates the full 4-bit condition set
// against the selected bank. Every instruction is predicated, and a taken jump opens a
// FLUSH_CYCLES-long squash window.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   en         instruction valid this cycle
//   cond       4-bit condition code
//   is_jmp     instruction is a jump
//   flag_we    instruction writes flags
//   alu_nzcv   {N,Z,C,V} from the ALU
//   bank_sel   flag bank for evaluation, write and flags_o
//   exec_ok    registered: previous-cycle instruction executes
//   jmp_taken  registered: previous-cycle jump taken
//   flush      registered: squash window active
//   flags_o    combinational view of the selected bank, {N,Z,C,V}
module cond_exec_unit #(
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        cond,
  input  logic              is_jmp,
  input  logic              flag_we,
  input  logic [3:0]        alu_nzcv,
  input  logic [BANK_W-1:0] bank_sel,
  output logic              exec_ok,
  output logic              jmp_taken,
  output logic              flush,
  output logic [3:0]        flags_o
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [3:0]        banks_q [NUM_BANKS];
  logic [BANK_W-1:0] bank_idx;
  logic [3:0]        cur;
  logic              n, z, c, v;
  logic              cond_true;
  logic              squash, live, pass, load_flush;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Out-of-range selects alias to bank 0 for both read and write.
  assign bank_idx = (32'(bank_sel) < NUM_BANKS) ? bank_sel : '0;
  assign cur      = banks_q[bank_idx];
  assign flags_o  = cur;
  assign {n, z, c, v} = cur;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'h0: cond_true = z;
      4'h1: cond_true = ~z;
      4'h2: cond_true = c;
      4'h3: cond_true = ~c;
      4'h4: cond_true = n;
      4'h5: cond_true = ~n;
      4'h6: cond_true = v;
      4'h7: cond_true = ~v;
      4'h8: cond_true = c & ~z;
      4'h9: cond_true = ~c | z;
      4'hA: cond_true = (n == v);
      4'hB: cond_true = (n != v);
      4'hC: cond_true = ~z & (n == v);
      4'hD: cond_true = z | (n != v);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
    endcase
  end

  // The squash window is driven by the counter itself, so it lines up exactly with flush.
  assign squash     = (cnt_q != '0);
  assign live       = en & ~squash;
  assign pass       = live & cond_true;
  assign load_flush = pass & is_jmp & (FLUSH_CYCLES != 0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_flush) begin
      cnt_d = CNT_W'(FLUSH_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_ok   <= 1'b0;
      jmp_taken <= 1'b0;
      flush     <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        banks_q[i] <= 4'b0000;
      end
    end else begin
      exec_ok   <= pass;
      jmp_taken <= pass & is_jmp;
      flush     <= (cnt_d != '0);
      cnt_q     <= cnt_d;
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (pass && flag_we && (bank_idx == BANK_W'(i))) begin
          banks_q[i] <= alu_nzcv;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// tb_cond_exec_unit: table-driven bench for cond_exec_unit (NUM_BANKS=2, FLUSH_CYCLES=2).
// Each vector carries its hand-derived expected outputs; expectations are queued when the
// vector is driven and popped once the edge has been taken.
module tb_cond_exec_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] cond;
  logic       is_jmp;
  logic       flag_we;
  logic [3:0] alu_nzcv;
  logic [0:0] bank_sel;
  logic       exec_ok;
  logic       jmp_taken;
  logic       flush;
  logic [3:0] flags_o;

  cond_exec_unit #(
    .NUM_BANKS   (2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cond     (cond),
    .is_jmp   (is_jmp),
    .flag_we  (flag_we),
    .alu_nzcv (alu_nzcv),
    .bank_sel (bank_sel),
    .exec_ok  (exec_ok),
    .jmp_taken(jmp_taken),
    .flush    (flush),
    .flags_o  (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cond;
    logic       is_jmp;
    logic       flag_we;
    logic [3:0] alu;
    logic       bank;
    logic       exp_exec;
    logic       exp_jmp;
    logic       exp_flush;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs [20];
  vec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic e, logic [3:0] cd, logic j, logic we,
                              logic [3:0] alu, logic b, logic x_exec, logic x_jmp,
                              logic x_flush, logic [3:0] x_flags);
    vec_t t;
    t.rst = r; t.en = e; t.cond = cd; t.is_jmp = j; t.flag_we = we; t.alu = alu;
    t.bank = b; t.exp_exec = x_exec; t.exp_jmp = x_jmp; t.exp_flush = x_flush;
    t.exp_flags = x_flags;
    return t;
  endfunction

  task automatic check(string name, int idx, logic [3:0] act, logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; cond = v.cond; is_jmp = v.is_jmp;
    flag_we = v.flag_we; alu_nzcv = v.alu; bank_sel = v.bank;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("exec_ok",   idx, {3'b0, exec_ok},   {3'b0, e.exp_exec});
    check("jmp_taken", idx, {3'b0, jmp_taken}, {3'b0, e.exp_jmp});
    check("flush",     idx, {3'b0, flush},     {3'b0, e.exp_flush});
    check("flags_o",   idx, flags_o,           e.exp_flags);
  endtask

  initial begin
    int fl_cnt;
    rst = 1'b1; en = 1'b0; cond = 4'h0; is_jmp = 1'b0; flag_we = 1'b0;
    alu_nzcv = 4'h0; bank_sel = 1'b0;

    //            rst en  cond  jmp we  alu     bk   exec jmp flush flags
    vecs[0]  = mk(1, 1, 4'hE, 1, 1, 4'b1111, 0,  0, 0, 0, 4'b0000); // reset wins
    vecs[1]  = mk(0, 1, 4'hE, 0, 1, 4'b0100, 0,  1, 0, 0, 4'b0100); // set Z
    vecs[2]  = mk(0, 1, 4'h0, 1, 0, 4'b0000, 0,  1, 1, 1, 4'b0100); // EQ jump taken
    vecs[3]  = mk(0, 0, 4'h0, 0, 0, 4'b0000, 0,  0, 0, 1, 4'b0100); // flush cycle 2
    vecs[4]  = mk(0, 0, 4'h0, 0, 0, 4'b0000, 0,  0, 0, 0, 4'b0100); // flush over
    vecs[5]  = mk(0, 1, 4'hE, 0, 1, 4'b1000, 0,  1, 0, 0, 4'b1000); // N=1
    vecs[6]  = mk(0, 1, 4'hC, 1, 0, 4'b0000, 0,  0, 0, 0, 4'b1000); // GT fails
    vecs[7]  = mk(0, 1, 4'hB, 1, 0, 4'b0000, 0,  1, 1, 1, 4'b1000); // LT taken
    vecs[8]  = mk(0, 1, 4'hE, 1, 1, 4'b1111, 0,  0, 0, 1, 4'b1000); // squashed
    vecs[9]  = mk(0, 0, 4'h0, 0, 0, 4'b0000, 0,  0, 0, 0, 4'b1000); // not extended
    vecs[10] = mk(0, 1, 4'hE, 0, 1, 4'b0100, 0,  1, 0, 0, 4'b0100); // instr A
    vecs[11] = mk(0, 1, 4'h1, 1, 0, 4'b0000, 0,  0, 0, 0, 4'b0100); // instr B NE
    vecs[12] = mk(0, 1, 4'hE, 0, 1, 4'b0011, 1,  1, 0, 0, 4'b0011); // bank1 write
    vecs[13] = mk(0, 0, 4'h0, 0, 0, 4'b0000, 0,  0, 0, 0, 4'b0100); // bank0 intact
    vecs[14] = mk(0, 1, 4'hF, 0, 1, 4'b1111, 1,  0, 0, 0, 4'b0011); // NV no write
    vecs[15] = mk(0, 1, 4'h2, 0, 0, 4'b0000, 1,  1, 0, 0, 4'b0011); // CS
    vecs[16] = mk(0, 1, 4'h7, 0, 0, 4'b0000, 1,  0, 0, 0, 4'b0011); // VC fails
    vecs[17] = mk(0, 1, 4'h8, 1, 1, 4'b0110, 1,  1, 1, 1, 4'b0110); // HI, old flags
    vecs[18] = mk(1, 0, 4'h0, 0, 0, 4'b0000, 1,  0, 0, 0, 4'b0000); // rst mid-flush
    vecs[19] = mk(0, 1, 4'h0, 0, 0, 4'b0000, 0,  0, 0, 0, 4'b0000); // EQ after reset

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], i);
    end

    // Count the flush window after a taken jump, bounded to a fixed cycle budget.
    apply(mk(1, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000), 100);
    apply(mk(0, 1, 4'hE, 0, 1, 4'b0100, 0, 1, 0, 0, 4'b0100), 101);
    apply(mk(0, 1, 4'h0, 1, 0, 4'b0000, 0, 1, 1, 1, 4'b0100), 102);
    fl_cnt = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en = 1'b0; is_jmp = 1'b0; flag_we = 1'b0;
      @(posedge clk);
      #1;
      if (flush === 1'b1) fl_cnt++;
    end
    check("flush_len", 103, 4'(fl_cnt), 4'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
